// File: rtl/free_list.sv
// ============================================================================
// Module      : free_list
// Description : Circular FIFO of free physical-register tags for rename.
//               Reset preloads every allocatable tag; head is fall-through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module free_list #(
   parameter int WIDTH = 5,
   parameter int SIZE  = 31,
   parameter int STNUM = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_re,
   input  logic             i_we,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic             o_full
);

   localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int CW = $clog2(SIZE + 1);
   localparam logic [PW-1:0] C_LAST  = PW'(SIZE - 1);
   localparam logic [CW-1:0] C_FULL  = CW'(SIZE);

   logic [WIDTH-1:0] mem_q [0:SIZE-1];
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign o_data  = mem_q[head_q];
   assign o_empty = (count_q == '0);
   assign o_full  = (count_q == C_FULL);

   // A push while full is legal only when a pop frees the slot this cycle.
   assign w_pop_ok  = i_re & ~o_empty;
   assign w_push_ok = i_we & (~o_full | i_re);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CW'(w_push_ok) - CW'(w_pop_ok);
      if (w_pop_ok) begin
         head_d = (head_q == C_LAST) ? '0 : head_q + PW'(1);
      end
      if (w_push_ok) begin
         tail_d = (tail_q == C_LAST) ? '0 : tail_q + PW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < SIZE; i++) begin
            mem_q[i] <= WIDTH'(STNUM + i);
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= C_FULL;
      end else begin
         if (w_push_ok) begin
            mem_q[tail_q] <= i_data;
         end
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_free_list.sv
// ============================================================================
// Module      : tb_free_list
// Description : Randomised and directed bench for free_list against a queue
//               model of the tag list.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_free_list;

   localparam int WIDTH = 5;
   localparam int SIZE  = 31;
   localparam int STNUM = 1;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic             re    = 1'b0;
   logic             we    = 1'b0;
   logic [WIDTH-1:0] din   = '0;
   logic [WIDTH-1:0] dout;
   logic             empty;
   logic             full;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] q [$];

   free_list #(.WIDTH(WIDTH), .SIZE(SIZE), .STNUM(STNUM)) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_re    (re),
      .i_we    (we),
      .i_data  (din),
      .o_data  (dout),
      .o_empty (empty),
      .o_full  (full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < SIZE; i++) q.push_back(WIDTH'(STNUM + i));
   endtask

   // o_data is only meaningful while the list holds a tag.
   task automatic check_outputs(input string tag);
      check({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
      check({tag, "_full"},  32'(full),  32'(q.size() == SIZE));
      if (q.size() > 0) check({tag, "_data"}, 32'(dout), 32'(q[0]));
   endtask

   task automatic cycle(input string tag, input logic r, input logic w, input logic [WIDTH-1:0] d);
      bit pop_ok, push_ok;
      re  = r;
      we  = w;
      din = d;
      @(posedge clk);
      pop_ok  = r && (q.size() > 0);
      push_ok = w && ((q.size() < SIZE) || r);
      if (pop_ok)  void'(q.pop_front());
      if (push_ok) q.push_back(d);
      #1;
      check_outputs(tag);
   endtask

   // Called just after a cycle; drops reset between clock edges.
   task automatic async_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check({tag, "_rst_data"}, 32'(dout), 32'(STNUM));
      check({tag, "_rst_full"}, 32'(full), 32'd1);
      check({tag, "_rst_empty"}, 32'(empty), 32'd0);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("reset_data", 32'(dout), 32'd1);
      check("reset_full", 32'(full), 32'd1);
      check("reset_empty", 32'(empty), 32'd0);

      for (int k = 0; k < 5; k++) cycle("idle", 1'b0, 1'b0, '0);
      check("idle_data", 32'(dout), 32'd1);

      // Loopback: head tag rotates with period SIZE while staying full.
      for (int k = 0; k < 70; k++) begin
         cycle("loop", 1'b1, 1'b1, q[0]);
         check("loop_seq", 32'(dout), 32'(((k + 1) % SIZE) + 1));
      end

      async_reset("drain");
      for (int k = 0; k < SIZE; k++) cycle("drain", 1'b1, 1'b0, '0);
      check("drain_empty", 32'(empty), 32'd1);
      for (int k = 0; k < 3; k++) cycle("underflow", 1'b1, 1'b0, '0);
      check("underflow_full", 32'(full), 32'd0);

      cycle("push7", 1'b0, 1'b1, 5'd7);
      check("push7_data", 32'(dout), 32'd7);
      cycle("push9", 1'b0, 1'b1, 5'd9);
      cycle("pop7", 1'b1, 1'b0, '0);
      check("pop7_data", 32'(dout), 32'd9);
      cycle("pop9", 1'b1, 1'b0, '0);
      check("pop9_empty", 32'(empty), 32'd1);

      cycle("empty_rw", 1'b1, 1'b1, 5'd12);
      check("empty_rw_data", 32'(dout), 32'd12);
      cycle("empty_rw_pop", 1'b1, 1'b0, '0);
      check("empty_rw_cnt", 32'(empty), 32'd1);

      async_reset("ovf");
      cycle("overflow", 1'b0, 1'b1, 5'd20);
      check("overflow_data", 32'(dout), 32'd1);
      for (int k = 0; k < 3; k++) cycle("pop3", 1'b1, 1'b0, '0);
      check("pop3_data", 32'(dout), 32'd4);
      async_reset("mid");

      // Random traffic with a drifting bias so both boundaries get visited.
      for (int k = 0; k < 4000; k++) begin
         int bias;
         logic r, w;
         bias = ((k / 200) % 2 == 0) ? 70 : 30;
         r = ($urandom_range(0, 99) < bias);
         w = ($urandom_range(0, 99) < (100 - bias));
         cycle("rand", r, w, WIDTH'($urandom));
         if ($urandom_range(0, 499) == 0) async_reset("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
